// File: rtl/tt_lpf_ctrl_if.sv
// Signal bundle between the loop-filter controller, the PFD, the loop filter
// scan chain and the top-level control pins.
interface tt_lpf_ctrl_if;
  logic        i_start;
  logic [31:0] i_preset;
  logic        i_up;
  logic        i_down;
  logic        o_up;
  logic        o_down;
  logic        o_scan_en;
  logic        o_scan_in;
  logic        i_scan_out;
  logic [31:0] o_snapshot;
  logic        o_snapshot_valid;
  logic        o_busy;
  logic        o_locked;
  logic [1:0]  o_state;

  modport master (
    input  i_start, i_preset, i_up, i_down, i_scan_out,
    output o_up, o_down, o_scan_en, o_scan_in, o_snapshot, o_snapshot_valid,
           o_busy, o_locked, o_state
  );

  modport slave (
    output i_start, i_preset, i_up, i_down, i_scan_out,
    input  o_up, o_down, o_scan_en, o_scan_in, o_snapshot, o_snapshot_valid,
           o_busy, o_locked, o_state
  );
endinterface

// File: rtl/tt_lpf_ctrl.sv
// PLL loop-filter sequencer: scan-chain warm start with accumulator snapshot,
// PFD pulse gating and a windowed activity lock detector.
module tt_lpf_ctrl #(
  parameter int WIN_LEN    = 64,
  parameter int QUIET_MAX  = 2,
  parameter int LOCK_WINS  = 4,
  parameter int UNLOCK_MAX = 8
) (
  input logic              i_clk,
  input logic              i_rst_n,
  tt_lpf_ctrl_if.master    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    ACQUIRE = 2'd2,
    LOCKED  = 2'd3
  } state_t;

  localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int ACT_W  = $clog2(UNLOCK_MAX + 1);
  localparam int QCNT_W = (LOCK_WINS > 1) ? $clog2(LOCK_WINS + 1) : 1;

  state_t              state;
  logic [31:0]         shift;
  logic [31:0]         snap;
  logic [31:0]         snapshot;
  logic [4:0]          bit_cnt;
  logic                snap_vld;
  logic                locked;
  logic [WIN_W-1:0]    win_cnt;
  logic [ACT_W-1:0]    act_cnt;
  logic [QCNT_W-1:0]   quiet_cnt;

  logic                tracking;
  logic                active;
  logic                win_end;
  logic                quiet;
  logic                loud;
  logic [ACT_W-1:0]    act_total;

  // Activity count saturates so a noisy window cannot wrap back to "quiet".
  function automatic logic [ACT_W-1:0] act_sat_inc(input logic [ACT_W-1:0] cnt,
                                                   input logic             inc);
    if (inc && (cnt < ACT_W'(UNLOCK_MAX)))
      return cnt + ACT_W'(1);
    return cnt;
  endfunction

  assign tracking  = (state == ACQUIRE) || (state == LOCKED);
  // up=down=1 decodes as zero phase error in the filter, so it is not activity.
  assign active    = bus.i_up ^ bus.i_down;
  assign act_total = act_sat_inc(act_cnt, active);
  assign win_end   = (win_cnt == WIN_W'(WIN_LEN - 1));
  assign quiet     = (act_total <= ACT_W'(QUIET_MAX));
  assign loud      = (act_total >= ACT_W'(UNLOCK_MAX));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      shift     <= '0;
      snap      <= '0;
      snapshot  <= '0;
      bit_cnt   <= '0;
      snap_vld  <= 1'b0;
      locked    <= 1'b0;
      win_cnt   <= '0;
      act_cnt   <= '0;
      quiet_cnt <= '0;
    end else begin
      snap_vld <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            shift   <= bus.i_preset;
            bit_cnt <= '0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          shift   <= {shift[30:0], 1'b0};
          snap    <= {snap[30:0], bus.i_scan_out};
          bit_cnt <= bit_cnt + 5'd1;
          if (bit_cnt == 5'd31) begin
            snapshot  <= {snap[30:0], bus.i_scan_out};
            snap_vld  <= 1'b1;
            state     <= ACQUIRE;
            win_cnt   <= '0;
            act_cnt   <= '0;
            quiet_cnt <= '0;
          end
        end
        ACQUIRE, LOCKED: begin
          // A restart request overrides any window-end evaluation this cycle.
          if (bus.i_start) begin
            shift   <= bus.i_preset;
            bit_cnt <= '0;
            state   <= LOAD;
            locked  <= 1'b0;
          end else if (!win_end) begin
            win_cnt <= win_cnt + WIN_W'(1);
            act_cnt <= act_total;
          end else begin
            win_cnt <= '0;
            act_cnt <= '0;
            if (state == ACQUIRE) begin
              if (!quiet) begin
                quiet_cnt <= '0;
              end else if (quiet_cnt == QCNT_W'(LOCK_WINS - 1)) begin
                quiet_cnt <= '0;
                state     <= LOCKED;
                locked    <= 1'b1;
              end else begin
                quiet_cnt <= quiet_cnt + QCNT_W'(1);
              end
            end else if (loud) begin
              quiet_cnt <= '0;
              state     <= ACQUIRE;
              locked    <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_up             = bus.i_up & tracking;
  assign bus.o_down           = bus.i_down & tracking;
  assign bus.o_scan_en        = (state == LOAD);
  assign bus.o_scan_in        = shift[31];
  assign bus.o_snapshot       = snapshot;
  assign bus.o_snapshot_valid = snap_vld;
  assign bus.o_busy           = (state == LOAD);
  assign bus.o_locked         = locked;
  assign bus.o_state          = state;

endmodule
